// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline register: occupancy states and
// bit positions inside the write-back control field.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int REGWRITE_BIT = 0;
    localparam int MEMTOREG_BIT = 1;

endpackage

// File: rtl/pipe_entry_reg.sv
// One MEM/WB entry (control, read data, ALU result, destination) held in an
// enable-loaded register bank that clears on reset.
module pipe_entry_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] read_data_d,
    input  logic [DATA_W-1:0] alu_result_d,
    input  logic [ADDR_W-1:0] dst_addr_d,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] read_data_q,
    output logic [DATA_W-1:0] alu_result_q,
    output logic [ADDR_W-1:0] dst_addr_q
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_q       <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            dst_addr_q   <= '0;
        end else if (load) begin
            ctrl_q       <= ctrl_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            dst_addr_q   <= dst_addr_d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, optional two-entry skid
// buffer, flush, and write-back data / forwarding outputs taken from the head.
module mem_wb_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [ADDR_W-1:0] dst_addr_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [ADDR_W-1:0] dst_addr_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_en,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    pipe_state_t state_reg, state_next;

    logic accept, consume;
    logic head_load, head_from_skid, skid_load;

    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_read_data, skid_alu_result;
    logic [ADDR_W-1:0] skid_dst_addr;

    logic [CTRL_W-1:0] head_ctrl_d;
    logic [DATA_W-1:0] head_read_data_d, head_alu_result_d;
    logic [ADDR_W-1:0] head_dst_addr_d;

    assign out_valid = (state_reg != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Flush overrides everything; an entry arriving with it is never loaded.
    always_comb begin
        state_next     = state_reg;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        head_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        state_next = TWO;
                        skid_load  = 1'b1;
                    end else if (consume) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_next     = ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    assign head_ctrl_d       = head_from_skid ? skid_ctrl       : ctrl_in;
    assign head_read_data_d  = head_from_skid ? skid_read_data  : read_data_in;
    assign head_alu_result_d = head_from_skid ? skid_alu_result : alu_result_in;
    assign head_dst_addr_d   = head_from_skid ? skid_dst_addr   : dst_addr_in;

    pipe_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_head (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .load         (head_load),
        .ctrl_d       (head_ctrl_d),
        .read_data_d  (head_read_data_d),
        .alu_result_d (head_alu_result_d),
        .dst_addr_d   (head_dst_addr_d),
        .ctrl_q       (ctrl_out),
        .read_data_q  (read_data_out),
        .alu_result_q (alu_result_out),
        .dst_addr_q   (dst_addr_out)
    );

    generate
        if (SKID != 0) begin : g_skid
            // Ready is a decode of the registered state only, so out_ready
            // never reaches in_ready combinationally.
            assign in_ready = (state_reg != TWO);

            pipe_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_skid (
                .CLK          (CLK),
                .RST_N        (RST_N),
                .load         (skid_load),
                .ctrl_d       (ctrl_in),
                .read_data_d  (read_data_in),
                .alu_result_d (alu_result_in),
                .dst_addr_d   (dst_addr_in),
                .ctrl_q       (skid_ctrl),
                .read_data_q  (skid_read_data),
                .alu_result_q (skid_alu_result),
                .dst_addr_q   (skid_dst_addr)
            );
        end else begin : g_no_skid
            assign in_ready        = !out_valid || out_ready;
            assign skid_ctrl       = '0;
            assign skid_read_data  = '0;
            assign skid_alu_result = '0;
            assign skid_dst_addr   = '0;
        end
    endgenerate

    assign wb_data  = ctrl_out[MEMTOREG_BIT] ? read_data_out : alu_result_out;
    assign fwd_en   = out_valid && ctrl_out[REGWRITE_BIT] && (dst_addr_out != '0);
    assign fwd_addr = dst_addr_out;
    assign fwd_data = wb_data;

endmodule

// File: doc/mem_wb_pipe_reg.md
MEM_WB_PIPE_REG -- requirements
Module: mem_wb_pipe_reg

Interface
REQ-001 Parameter DATA_W, 32, width of read data and ALU result.
REQ-002 Parameter ADDR_W, 5, width of destination register address.
REQ-003 Parameter CTRL_W, 2, width of WB control; bit0 RegWrite, bit1 MemtoReg; CTRL_W >= 2.
REQ-004 Parameter SKID, 1, 1 = two-entry skid buffer, 0 = single entry with combinational in_ready.
REQ-005 CLK  in  1  sole clock, all state on rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  MEM stage presents a valid instruction.
REQ-008 in_ready  out  1  stage accepts the input this cycle.
REQ-009 ctrl_in  in  CTRL_W  WB control from MEM.
REQ-010 read_data_in / alu_result_in  in  DATA_W each  memory read data and ALU result.
REQ-011 dst_addr_in  in  ADDR_W  destination register.
REQ-012 flush  in  1  synchronous kill of all held and incoming entries.
REQ-013 out_valid  out  1  WB entry valid; out_ready  in  1  WB consumes it.
REQ-014 ctrl_out, read_data_out, alu_result_out, dst_addr_out  out  as inputs  registered head entry.
REQ-015 wb_data  out  DATA_W  ctrl_out[1] ? read_data_out : alu_result_out.
REQ-016 fwd_en  out  1  out_valid & ctrl_out[0] & (dst_addr_out != 0); fwd_addr/fwd_data  out  ADDR_W/DATA_W  = dst_addr_out/wb_data.

Function
REQ-017 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready.
REQ-018 Latency one cycle: an entry accepted at edge N appears on outputs after edge N when the stage was empty or draining.
REQ-019 SKID=1 states: EMPTY, ONE (head full), TWO (head + skid full); in_ready = (state != TWO), registered, no combinational path from out_ready.
REQ-020 EMPTY: accept -> ONE; else stay.
REQ-021 ONE: accept & consume -> ONE, head replaced; accept only -> TWO, input to skid; consume only -> EMPTY; neither -> stay.
REQ-022 TWO: consume -> ONE, skid moves to head; no accept possible.
REQ-023 SKID=0: in_ready = !out_valid | out_ready; single head register, states EMPTY/ONE only.
REQ-024 Ordering strictly FIFO; no entry duplicated or dropped except by flush.
REQ-025 Data outputs hold value while out_valid & !out_ready (stall); unchanged when out_valid=0.
REQ-026 flush: next state EMPTY regardless of in_valid/out_ready; same-cycle input discarded; in_ready=1 next cycle.
REQ-027 Outputs wb_data and fwd_* combinational from head registers only; fwd_en=0 whenever out_valid=0.
REQ-028 Write to register 0 valid in pipeline but never forwarded.

Reset
REQ-029 RST_N low asynchronously forces state EMPTY, out_valid=0, in_ready=1 (SKID=1 after release), all data/control registers 0.
REQ-030 Reset mid-transfer discards all entries; first accept after release behaves as from EMPTY.

Structure
REQ-031 Shared package pipe_pkg holds state enum (EMPTY/ONE/TWO), control bit index constants REGWRITE_BIT=0, MEMTOREG_BIT=1.
REQ-032 One sub-module pipe_entry_reg: enable-loaded register bundling ctrl/read_data/alu_result/dst_addr, instantiated for head and (SKID=1) skid.
REQ-033 No negedge logic; single clock domain.

Verification
REQ-034 Reset: RST_N=0 mid-cycle with ONE held -> out_valid=0, ctrl_out=0 immediately; in_ready=1 after release.
REQ-035 Streaming: in_valid=1, out_ready=1, 8 entries alu_result=1..8 -> one per cycle, order 1..8, latency 1.
REQ-036 Stall: out_ready=0 after entry A=0xAAAA, push B=0xBBBB -> state TWO, in_ready=0, outputs hold A; out_ready=1 -> A then B.
REQ-037 Flush in TWO with in_valid=1 -> next cycle out_valid=0, state EMPTY, none of the three entries appear.
REQ-038 Forwarding: ctrl=2'b11, dst=7, read_data=0x1234, alu=0x5678 -> wb_data=0x1234, fwd_en=1, fwd_addr=7; dst=0 -> fwd_en=0.
REQ-039 SKID=0 build: out_ready=0 with head full -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
